// File: rtl/trace_serial_arbiter.sv
// Round-robin arbiter that serialises one requester's payload per frame.
// Frame on `out`, LSB first: start bit 1, requester id, then payload.
// Optional idle GAP cycles follow each frame. All outputs come straight from flops.
module trace_serial_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16,
    parameter int GAP   = 1
) (
    input  logic                   clk,
    input  logic                   rst_all_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] data,
    output logic [N_REQ-1:0]       ack,
    output logic                   out,
    output logic                   out_valid,
    output logic                   busy
);

    localparam int IDW   = $clog2(N_REQ);
    localparam int FRAME = 1 + IDW + WIDTH;
    localparam int CW    = $clog2(FRAME);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t             state, state_next;
    logic [CW-1:0]      cnt, cnt_next;
    logic [2:0]         gcnt, gcnt_next;
    logic [FRAME-2:0]   sreg, sreg_next;
    logic [IDW-1:0]     last_grant, last_grant_next;
    logic [N_REQ-1:0]   ack_next;
    logic               out_next;
    logic               valid_next;
    logic               busy_next;

    logic               grant_found;
    logic [IDW-1:0]     grant_idx;
    logic [IDW-1:0]     cand;
    logic [WIDTH-1:0]   grant_data;
    logic [FRAME-1:0]   frame;

    // Requester visited at position `offset` of a search starting after `base`.
    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int offset);
        int idx;
        idx = int'(base) + 1 + offset;
        if (idx >= N_REQ) begin
            idx = idx - N_REQ;
        end
        return IDW'(idx);
    endfunction

    // Round-robin pick of the first requesting line after the last grant, plus its frame.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = rr_index(last_grant, i);
            if (!grant_found && req[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        grant_data = data[int'(grant_idx)*WIDTH +: WIDTH];
        frame      = {grant_data, grant_idx, 1'b1};
    end

    // Next-state and next-output logic; outputs default to the idle values.
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        gcnt_next       = gcnt;
        sreg_next       = sreg;
        last_grant_next = last_grant;
        ack_next        = '0;
        out_next        = 1'b0;
        valid_next      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (grant_found) begin
                    state_next          = ST_SHIFT;
                    cnt_next            = '0;
                    sreg_next           = frame[FRAME-1:1];
                    out_next            = frame[0];
                    valid_next          = 1'b1;
                    ack_next[grant_idx] = 1'b1;
                    last_grant_next     = grant_idx;
                end
            end
            ST_SHIFT: begin
                if (cnt == CW'(FRAME - 1)) begin
                    // Counter parks at the last index until the next grant.
                    state_next = (GAP > 0) ? ST_GAP : ST_IDLE;
                    gcnt_next  = '0;
                end else begin
                    cnt_next   = cnt + 1'b1;
                    out_next   = sreg[0];
                    valid_next = 1'b1;
                    sreg_next  = sreg >> 1;
                end
            end
            ST_GAP: begin
                if (gcnt == 3'(GAP - 1)) begin
                    state_next = ST_IDLE;
                end else begin
                    gcnt_next = gcnt + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst_all_n) begin
        if (!rst_all_n) begin
            // NOTE: the shift register is cleared too, so an aborted frame leaves no residue.
            state      <= ST_IDLE;
            cnt        <= '0;
            gcnt       <= '0;
            sreg       <= '0;
            last_grant <= IDW'(N_REQ - 1);
            ack        <= '0;
            out        <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            state      <= state_next;
            cnt        <= cnt_next;
            gcnt       <= gcnt_next;
            sreg       <= sreg_next;
            last_grant <= last_grant_next;
            ack        <= ack_next;
            out        <= out_next;
            out_valid  <= valid_next;
            busy       <= busy_next;
        end
    end

endmodule

// File: tb/tb_trace_serial_arbiter.sv
// Scoreboard bench for trace_serial_arbiter: stimulus queues expected frames,
// a monitor rebuilds frames from out/out_valid and compares them.
module tb_trace_serial_arbiter;

    localparam int N_REQ = 4;
    localparam int WIDTH = 16;
    localparam int FRAME = 19;

    typedef struct {
        logic [FRAME-1:0] frame;
        logic [3:0]       onehot;
        int               spacing;
        int               abort_len;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_all_n = 1'b0;
    logic [3:0]  req = '0;
    logic [63:0] data = '0;
    logic [3:0]  ack;
    logic        out, out_valid, busy;

    logic [3:0]  req_g0 = '0;
    logic [63:0] data_g0 = '0;
    logic [3:0]  ack_g0;
    logic        out_g0, out_valid_g0, busy_g0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    exp_t             sb[$];
    exp_t             cur;
    logic             collecting = 1'b0;
    logic             prev_valid = 1'b0;
    int               nbits = 0;
    int               last_start = 0;
    logic [FRAME-1:0] bits;
    logic [FRAME-1:0] mask;

    logic [FRAME-1:0] g0_frame = '0;
    int               frames_g0 = 0;
    int               low_g0 = 0;
    int               nb_g0 = 0;
    logic [FRAME-1:0] bits_g0;
    logic             pv_g0 = 1'b0;

    trace_serial_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .GAP(1)) u_dut (
        .clk(clk), .rst_all_n(rst_all_n), .req(req), .data(data),
        .ack(ack), .out(out), .out_valid(out_valid), .busy(busy)
    );

    trace_serial_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .GAP(0)) u_dut_g0 (
        .clk(clk), .rst_all_n(rst_all_n), .req(req_g0), .data(data_g0),
        .ack(ack_g0), .out(out_g0), .out_valid(out_valid_g0), .busy(busy_g0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: observed %0h (t=%0t)", name, act, $time);
    endtask

    // Frame as sent LSB first: start bit, 2-bit id, 16-bit payload.
    function automatic logic [FRAME-1:0] make_frame(input logic [1:0] id, input logic [15:0] d);
        return {d, id, 1'b1};
    endfunction

    task automatic expect_frame(input logic [1:0] id, input logic [15:0] d,
                                input int spacing, input int abort_len);
        exp_t e;
        e.frame     = make_frame(id, d);
        e.onehot    = 4'b0001 << id;
        e.spacing   = spacing;
        e.abort_len = abort_len;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || collecting || busy) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_timeout", 64'(n < budget), 64'd1);
    endtask

    // Main monitor: rebuild each frame and compare against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_all_n) begin
                if (collecting) begin
                    if (sb.size() == 0) begin
                        fail_now("abort_unexpected", 64'(nbits));
                    end else begin
                        cur  = sb.pop_front();
                        mask = {FRAME{1'b1}} >> (FRAME - cur.abort_len);
                        check("abort_len", 64'(nbits), 64'(cur.abort_len));
                        check("abort_bits", 64'(bits & mask), 64'(cur.frame & mask));
                    end
                    collecting = 1'b0;
                end
                prev_valid = 1'b0;
            end else begin
                if (ack !== 4'b0000 && !(out_valid && !prev_valid)) begin
                    fail_now("ack_outside_start", 64'(ack));
                end
                if (out_valid && !prev_valid) begin
                    if (sb.size() == 0) begin
                        fail_now("unexpected_frame", 64'(ack));
                    end else begin
                        cur = sb[0];
                        check("ack", 64'(ack), 64'(cur.onehot));
                        if (cur.spacing != 0) begin
                            check("spacing", 64'(cyc - last_start), 64'(cur.spacing));
                        end
                        collecting = 1'b1;
                    end
                    last_start = cyc;
                    nbits      = 0;
                    bits       = '0;
                end
                if (out_valid) begin
                    if (nbits < FRAME) bits[nbits] = out;
                    nbits++;
                end
                if (!out_valid && prev_valid && collecting) begin
                    cur = sb.pop_front();
                    check("frame_len", 64'(nbits), 64'(FRAME));
                    check("frame_bits", 64'(bits), 64'(cur.frame));
                    check("gap_out", 64'(out), 64'd0);
                    check("gap_busy", 64'(busy), 64'd1);
                    collecting = 1'b0;
                end
                prev_valid = out_valid;
            end
        end
    end

    // GAP=0 monitor: frame contents and exactly one idle cycle between frames.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_all_n) begin
                pv_g0 = 1'b0;
            end else begin
                if (out_valid_g0 && !pv_g0) begin
                    if (frames_g0 > 0) check("g0_low_cycles", 64'(low_g0), 64'd1);
                    check("g0_ack", 64'(ack_g0), 64'h1);
                    nb_g0   = 0;
                    bits_g0 = '0;
                end
                if (out_valid_g0) begin
                    if (nb_g0 < FRAME) bits_g0[nb_g0] = out_g0;
                    nb_g0++;
                    low_g0 = 0;
                end else begin
                    low_g0++;
                end
                if (!out_valid_g0 && pv_g0) begin
                    check("g0_len", 64'(nb_g0), 64'(FRAME));
                    check("g0_bits", 64'(bits_g0), 64'(g0_frame));
                    check("g0_busy_after", 64'(busy_g0), 64'd0);
                    frames_g0++;
                end
                pv_g0 = out_valid_g0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        rst_all_n = 1'b0;
        #12;
        check("rst_out", 64'(out), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ack", 64'(ack), 64'd0);
        @(posedge clk); #1;
        rst_all_n = 1'b1;

        // Single request, payload A5C3 from requester 0.
        data[15:0] = 16'hA5C3;
        expect_frame(2'd0, 16'hA5C3, 0, 0);
        req = 4'b0001;
        @(posedge clk); #1;
        req = 4'b0000;
        wait_idle(100);

        // Full contention from reset: 0,1,2,3,0 every 21 cycles.
        rst_all_n = 1'b0;
        @(posedge clk); #1;
        rst_all_n = 1'b1;
        data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        expect_frame(2'd0, 16'h1111, 0, 0);
        expect_frame(2'd1, 16'h2222, 21, 0);
        expect_frame(2'd2, 16'h3333, 21, 0);
        expect_frame(2'd3, 16'h4444, 21, 0);
        expect_frame(2'd0, 16'h1111, 21, 0);
        req = 4'b1111;
        repeat (85) @(posedge clk);
        #1;
        req = 4'b0000;
        wait_idle(200);

        // Fairness: grant 2 alone, then 0101 pending gives 0 then 2.
        data[47:32] = 16'h0C0C;
        data[15:0]  = 16'h00F0;
        expect_frame(2'd2, 16'h0C0C, 0, 0);
        expect_frame(2'd0, 16'h00F0, 21, 0);
        expect_frame(2'd2, 16'h0C0C, 21, 0);
        req = 4'b0100;
        @(posedge clk); #1;
        req = 4'b0101;
        repeat (42) @(posedge clk);
        #1;
        req = 4'b0000;
        wait_idle(200);

        // Payload rewritten mid-frame; a short req pulse during SHIFT is never acked.
        data[31:16] = 16'h1234;
        expect_frame(2'd1, 16'h1234, 0, 0);
        req = 4'b0010;
        @(posedge clk); #1;
        req = 4'b0000;
        repeat (4) @(posedge clk);
        #1;
        data[31:16] = 16'hFFFF;
        req = 4'b1000;
        repeat (3) @(posedge clk);
        #1;
        req = 4'b0000;
        wait_idle(100);

        // Reset at bit 10 aborts the frame; requester 1 then gets a full frame.
        data[63:48] = 16'hBEEF;
        expect_frame(2'd3, 16'hBEEF, 0, 10);
        req = 4'b1000;
        @(posedge clk); #1;
        req = 4'b0000;
        repeat (10) @(posedge clk);
        #1;
        rst_all_n = 1'b0;
        #1;
        check("abort_out", 64'(out), 64'd0);
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_ack", 64'(ack), 64'd0);
        data[31:16] = 16'h0F0F;
        expect_frame(2'd1, 16'h0F0F, 0, 0);
        req = 4'b0010;
        @(posedge clk); #1;
        rst_all_n = 1'b1;
        @(posedge clk); #1;
        req = 4'b0000;
        wait_idle(100);

        // GAP=0 instance: requester 0 held for two frames.
        data_g0[15:0] = 16'h5A5A;
        g0_frame = make_frame(2'd0, 16'h5A5A);
        req_g0 = 4'b0001;
        repeat (21) @(posedge clk);
        #1;
        req_g0 = 4'b0000;
        repeat (30) @(posedge clk);
        #1;
        check("g0_frames", 64'(frames_g0), 64'd2);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
